// File: rtl/digit_blink_sequencer_pkg.sv
// Shared types and constants for the digit blink sequencer.
package digit_blink_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_SYNC = 3'd2,
    S_ON   = 3'd3,
    S_OFF  = 3'd4,
    S_GAP  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  localparam int DIGIT_W_DEF     = 4;
  localparam int ZERO_BLINKS_DEF = 10;
  localparam int MAX_DIGIT       = 9;
  localparam int BLINK_W         = 4;

endpackage

// File: rtl/digit_blink_sequencer_if.sv
// Digit handshake, divider control and LED side of the blink sequencer.
interface digit_blink_sequencer_if
  import digit_blink_sequencer_pkg::*;
#(
  parameter int DIGIT_W = DIGIT_W_DEF
);
  logic               digit_valid;
  logic               digit_ready;
  logic [DIGIT_W-1:0] digit;
  logic               tick_in;
  logic               div_enable;
  logic               div_reset;
  logic               led;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output digit_valid, digit, tick_in,
    input  digit_ready, div_enable, div_reset, led, busy, done, err
  );

  modport slave (
    input  digit_valid, digit, tick_in,
    output digit_ready, div_enable, div_reset, led, busy, done, err
  );
endinterface

// File: rtl/digit_blink_sequencer_tick_edge_detect.sv
// Turns every edge of the divider toggle into a one-cycle tick, with a
// short mask window that hides the divider's reset-forced high level.
module digit_blink_sequencer_tick_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic tick_in,
  input  logic arm_set,
  input  logic arm_clr,
  output logic tick
);
  logic tick_prev;
  logic arm_mask;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick_prev <= 1'b1;
      arm_mask  <= 1'b0;
    end else begin
      // Park at the divider's reset level so the forced 1 never reads as an edge.
      tick_prev <= arm_mask ? 1'b1 : tick_in;
      if (arm_set)      arm_mask <= 1'b1;
      else if (arm_clr) arm_mask <= 1'b0;
    end
  end

  assign tick = (tick_in ^ tick_prev) & ~arm_mask;
endmodule

// File: rtl/digit_blink_sequencer.sv
// Plays an accepted digit as a burst of LED blinks paced by the divider
// toggle, then a fixed dark gap and a done (and err for digits above 9).
module digit_blink_sequencer
  import digit_blink_sequencer_pkg::*;
#(
  parameter int DIGIT_W     = DIGIT_W_DEF,
  parameter int GAP_TICKS   = 4,
  parameter int ZERO_BLINKS = ZERO_BLINKS_DEF
) (
  input logic clock,
  input logic reset,
  digit_blink_sequencer_if.slave bus
);
  localparam int GAP_W = $clog2(GAP_TICKS + 1);

  state_t             state, state_n;
  logic [BLINK_W-1:0] blinks_left, blinks_n;
  logic [GAP_W-1:0]   gap_cnt, gap_n;
  logic               err_pending, errp_n;
  logic               led_q, led_n;
  logic               en_q, en_n;
  logic               drst_q, drst_n;
  logic               done_q, done_n;
  logic               err_q, err_n;
  logic               busy_q;
  logic               arm_set, arm_clr, tick;

  digit_blink_sequencer_tick_edge_detect u_tick (
    .clock   (clock),
    .reset   (reset),
    .tick_in (bus.tick_in),
    .arm_set (arm_set),
    .arm_clr (arm_clr),
    .tick    (tick)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      blinks_left <= '0;
      gap_cnt     <= '0;
      err_pending <= 1'b0;
      led_q       <= 1'b0;
      en_q        <= 1'b0;
      drst_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_n;
      blinks_left <= blinks_n;
      gap_cnt     <= gap_n;
      err_pending <= errp_n;
      led_q       <= led_n;
      en_q        <= en_n;
      drst_q      <= drst_n;
      done_q      <= done_n;
      err_q       <= err_n;
      busy_q      <= (state_n != S_IDLE);
    end
  end

  always_comb begin
    state_n  = state;
    blinks_n = blinks_left;
    gap_n    = gap_cnt;
    errp_n   = err_pending;
    led_n    = led_q;
    en_n     = en_q;
    drst_n   = 1'b0;
    done_n   = 1'b0;
    err_n    = 1'b0;
    arm_set  = 1'b0;
    arm_clr  = 1'b0;
    case (state)
      S_IDLE: if (bus.digit_valid) begin
        blinks_n = (bus.digit == '0) ? BLINK_W'(ZERO_BLINKS) : BLINK_W'(bus.digit);
        if (int'(bus.digit) > MAX_DIGIT) begin
          errp_n  = 1'b1;
          state_n = S_DONE;
        end else begin
          state_n = S_ARM;
        end
      end
      S_ARM: begin
        drst_n  = 1'b1;
        en_n    = 1'b0;
        arm_set = 1'b1;
        state_n = S_SYNC;
      end
      S_SYNC: begin
        en_n    = 1'b1;
        arm_clr = 1'b1;
        if (tick) begin
          led_n   = 1'b1;
          state_n = S_ON;
        end
      end
      S_ON: if (tick) begin
        led_n = 1'b0;
        if (blinks_left == BLINK_W'(1)) begin
          gap_n   = GAP_W'(GAP_TICKS);
          state_n = S_GAP;
        end else begin
          blinks_n = blinks_left - 1'b1;
          state_n  = S_OFF;
        end
      end
      S_OFF: if (tick) begin
        led_n   = 1'b1;
        state_n = S_ON;
      end
      S_GAP: begin
        led_n = 1'b0;
        if (tick) begin
          gap_n = gap_cnt - 1'b1;
          if (gap_cnt == GAP_W'(1)) state_n = S_DONE;
        end
      end
      S_DONE: begin
        done_n  = 1'b1;
        err_n   = err_pending;
        en_n    = 1'b0;
        errp_n  = 1'b0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign bus.digit_ready = (state == S_IDLE);
  assign bus.div_enable  = en_q;
  assign bus.div_reset   = drst_q;
  assign bus.led         = led_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_digit_blink_sequencer.sv
// Bench for digit_blink_sequencer: tick-counting reference model checked every
// cycle, directed bursts with hand-derived timing, then randomized traffic.
module tb_digit_blink_sequencer;
  import digit_blink_sequencer_pkg::*;

  localparam int GAP = 4;
  localparam int ZB  = 10;

  logic clock = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  digit_blink_sequencer_if #(.DIGIT_W(4)) bus ();

  digit_blink_sequencer #(.DIGIT_W(4), .GAP_TICKS(GAP), .ZERO_BLINKS(ZB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Divider stand-in: toggles every `half` enabled cycles, forced high by div_reset.
  int   half = 8;
  bit   free_run = 1'b0;
  bit   force_low = 1'b0;
  int   dcnt = 0;
  logic tick_q = 1'b1;

  always @(posedge clock) begin
    if (bus.div_reset) begin
      tick_q <= 1'b1;
      dcnt   <= 0;
    end else if (force_low) begin
      tick_q <= 1'b0;
    end else if (bus.div_enable || free_run) begin
      if (dcnt >= half - 1) begin
        tick_q <= ~tick_q;
        dcnt   <= 0;
      end else begin
        dcnt <= dcnt + 1;
      end
    end
  end
  assign bus.tick_in = tick_q;

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Reference: count tick edges from the third cycle after the handshake;
  // led is lit between odd and even edges, done lands two cycles after the last gap edge.
  bit         m_act = 1'b0;
  bit         m_err = 1'b0;
  int         m_rel, m_done_at, m_k, m_n, m_total, cyc = 0;
  logic       m_prev = 1'b1;
  logic [6:0] exp_o, got_o;

  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      exp_o = 7'b1000000;
      if (!reset) begin
        m_act = 1'b0;
      end else begin
        if (m_act) begin
          m_rel++;
          if (m_rel == m_done_at) begin
            exp_o = {1'b1, 4'b0000, 1'b1, m_err};
            m_act = 1'b0;
          end else begin
            exp_o = {1'b0, 1'b1, (!m_err && m_rel >= 3), (!m_err && m_rel == 2),
                     (!m_err && (m_k % 2 == 1) && m_k < 2 * m_n), 2'b00};
            if (!m_err && m_rel >= 3 && m_k < m_total &&
                bus.tick_in != ((m_rel == 3) ? 1'b1 : m_prev)) begin
              m_k++;
              if (m_k == m_total) m_done_at = m_rel + 2;
            end
          end
        end
        if (!m_act && bus.digit_valid) begin
          m_act     = 1'b1;
          m_rel     = 0;
          m_k       = 0;
          m_err     = (bus.digit > 4'd9);
          m_n       = (bus.digit == 4'd0) ? ZB : int'(bus.digit);
          m_total   = 2 * m_n + GAP;
          m_done_at = m_err ? 2 : -1;
        end
      end
      m_prev = bus.tick_in;
      got_o  = {bus.digit_ready, bus.busy, bus.div_enable, bus.div_reset, bus.led, bus.done, bus.err};
      vectors++;
      if (got_o !== exp_o) begin
        miscompares++;
        $display("FAIL cycle %0d outputs {rdy,busy,en,drst,led,done,err}: got %b, expected %b",
                 cyc, got_o, exp_o);
      end
    end
  end

  // Hand one digit over while idle and watch the burst until done.
  task automatic play(input logic [3:0] d, input int poke, output int pulses, output int hi,
                      output int rsts, output int done_rel, output int first_rise, output int err_seen);
    logic led_prev;
    pulses = 0; hi = 0; rsts = 0; done_rel = -1; first_rise = -1; err_seen = 0; led_prev = 1'b0;
    @(posedge clock); #1;
    bus.digit = d;
    bus.digit_valid = 1'b1;
    @(posedge clock); #1;
    bus.digit_valid = 1'b0;
    for (int c = 1; c < 400 && done_rel < 0; c++) begin
      @(negedge clock);
      if (bus.led && !led_prev) begin
        pulses++;
        if (first_rise < 0) first_rise = c;
      end
      if (bus.led) hi++;
      if (bus.div_reset) rsts++;
      if (bus.done) begin
        done_rel = c;
        err_seen = int'(bus.err);
      end
      led_prev = bus.led;
      if (c == poke) begin
        chk("ready while busy", int'(bus.digit_ready), 0);
        bus.digit = 4'd7;
        bus.digit_valid = 1'b1;
      end else if (c == poke + 1) begin
        bus.digit_valid = 1'b0;
      end
    end
  endtask

  initial begin
    int p, h, r, dr, fr, e;
    bit found;
    bus.digit_valid = 1'b0;
    bus.digit = 4'd0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    chk("reset led", int'(bus.led), 0);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset ready", int'(bus.digit_ready), 1);
    chk("reset div_enable", int'(bus.div_enable), 0);
    chk("reset done", int'(bus.done), 0);
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;

    play(4'd3, -10, p, h, r, dr, fr, e);
    chk("d3 pulses", p, 3);    chk("d3 led high cycles", h, 24);
    chk("d3 div_reset", r, 1); chk("d3 done cycle", dr, 85);
    chk("d3 first rise", fr, 12); chk("d3 err", e, 0);

    play(4'd0, -10, p, h, r, dr, fr, e);
    chk("d0 pulses", p, 10); chk("d0 led high cycles", h, 80);
    chk("d0 done cycle", dr, 197);

    play(4'd12, -10, p, h, r, dr, fr, e);
    chk("d12 pulses", p, 0); chk("d12 div_reset", r, 0);
    chk("d12 done cycle", dr, 2); chk("d12 err", e, 1);

    // Divider output low before arming: its forced high must not count as an edge.
    @(posedge clock); #1 force_low = 1'b1;
    @(posedge clock); #1 force_low = 1'b0;
    chk("tick low before arm", int'(bus.tick_in), 0);
    play(4'd1, -10, p, h, r, dr, fr, e);
    chk("d1 pulses", p, 1); chk("d1 first rise", fr, 12); chk("d1 done cycle", dr, 53);

    play(4'd2, 20, p, h, r, dr, fr, e);
    chk("d2 pulses", p, 2); chk("d2 led high cycles", h, 16); chk("d2 done cycle", dr, 69);

    // Reset in the middle of an ON phase.
    @(posedge clock); #1;
    bus.digit = 4'd5;
    bus.digit_valid = 1'b1;
    @(posedge clock); #1 bus.digit_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clock);
      if (bus.led) found = 1'b1;
    end
    chk("led lit before reset", int'(found), 1);
    #2 reset = 1'b0;
    #1;
    chk("async reset led", int'(bus.led), 0);
    chk("async reset busy", int'(bus.busy), 0);
    chk("async reset div_enable", int'(bus.div_enable), 0);
    chk("async reset ready", int'(bus.digit_ready), 1);
    @(negedge clock); @(negedge clock);
    #2 reset = 1'b1;
    play(4'd1, -10, p, h, r, dr, fr, e);
    chk("post reset pulses", p, 1); chk("post reset done cycle", dr, 53);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clock); #1;
      if (i % 250 == 0) begin
        half     = $urandom_range(1, 6);
        free_run = 1'($urandom_range(0, 1));
      end
      bus.digit_valid = ($urandom_range(0, 3) == 0);
      bus.digit = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
    end
    bus.digit_valid = 1'b0;
    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
